// File: rtl/rect_extract_pkg.sv
// Shared constants and helpers for the colour-rectangle extractor and its overlay consumer.
package rect_extract_pkg;

  localparam int RECT_NUMMAX = 4;
  localparam int OV5640_X    = 640;
  localparam int OV5640_Y    = 480;
  localparam int COLOR_WIDTH = 4;
  localparam int CNT_W       = 16;

  // Empty-slot marker: min corner at all-ones, max corner at zero, so the overlay draws nothing.
  localparam logic [31:0] RECT_EMPTY = 32'hFFFF_0000;

  function automatic logic [5:0] chan_diff(input logic [5:0] a, input logic [5:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/rect_extract_acc.sv
// One rectangle slot: colour-match stage, bounding-box/count accumulator and packed result.
module rect_acc
  import rect_extract_pkg::*;
#(
  parameter int C_W       = COLOR_WIDTH,
  parameter int P_W       = 12,
  parameter int CRD_SHIFT = 2,
  parameter int MIN_PIX   = 16
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           i_clr,
  input  logic           i_valid,
  input  logic [15:0]    i_data,
  input  logic [15:0]    i_target,
  input  logic [C_W+1:0] i_err,
  input  logic [P_W-1:0] i_x,
  input  logic [P_W-1:0] i_y,
  input  logic           i_pub,
  output logic [31:0]    o_item
);

  localparam int EW = C_W + 2;
  localparam int CW = (EW > 6) ? EW : 6;

  logic [5:0]       w_dr, w_dg, w_db;
  logic             w_hit;
  logic [P_W-1:0]   w_xmin_s, w_ymin_s, w_xmax_s, w_ymax_s;
  logic [31:0]      w_pack;

  logic             r_match;
  logic [P_W-1:0]   r_xmin, r_xmax, r_ymin, r_ymax;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_item;

  assign w_dr  = chan_diff({1'b0, i_data[15:11]}, {1'b0, i_target[15:11]});
  assign w_dg  = chan_diff(i_data[10:5], i_target[10:5]);
  assign w_db  = chan_diff({1'b0, i_data[4:0]}, {1'b0, i_target[4:0]});
  assign w_hit = i_valid && (CW'(w_dr) <= CW'(i_err)) && (CW'(w_dg) <= CW'(i_err))
                 && (CW'(w_db) <= CW'(i_err));

  assign w_xmin_s = r_xmin >> CRD_SHIFT;
  assign w_ymin_s = r_ymin >> CRD_SHIFT;
  assign w_xmax_s = r_xmax >> CRD_SHIFT;
  assign w_ymax_s = r_ymax >> CRD_SHIFT;
  assign w_pack   = {w_xmin_s[7:0], w_ymin_s[7:0], w_xmax_s[7:0], w_ymax_s[7:0]};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_match <= 1'b0;
      r_xmin  <= '1;
      r_ymin  <= '1;
      r_xmax  <= '0;
      r_ymax  <= '0;
      r_cnt   <= '0;
      r_item  <= RECT_EMPTY;
    end else begin
      r_match <= w_hit;
      // Publish reads the accumulators before a same-edge clear takes effect.
      if (i_pub)
        r_item <= (r_cnt < CNT_W'(MIN_PIX)) ? RECT_EMPTY : w_pack;
      if (i_clr) begin
        r_xmin <= '1;
        r_ymin <= '1;
        r_xmax <= '0;
        r_ymax <= '0;
        r_cnt  <= '0;
      end else if (r_match) begin
        if (i_x < r_xmin) r_xmin <= i_x;
        if (i_x > r_xmax) r_xmax <= i_x;
        if (i_y < r_ymin) r_ymin <= i_y;
        if (i_y > r_ymax) r_ymax <= i_y;
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_item = r_item;

endmodule

// File: rtl/rect_extract.sv
// Frame-level control for the rectangle extractor: raster counters, vs edges, shadow config.
module rect_extract
  import rect_extract_pkg::*;
#(
  parameter int C_W       = COLOR_WIDTH,
  parameter int P_W       = 12,
  parameter int N_RECT    = RECT_NUMMAX,
  parameter int CRD_SHIFT = 2,
  parameter int MIN_PIX   = 16,
  parameter int IMG_X     = OV5640_X,
  parameter int IMG_Y     = OV5640_Y
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  i_vs,
  input  logic                  i_valid,
  input  logic [15:0]           i_data,
  input  logic [C_W+1:0]        i_err,
  input  logic [N_RECT*16-1:0]  i_target,
  output logic [N_RECT*32-1:0]  o_item,
  output logic                  o_item_valid
);

  logic                 r_vs1, r_active, r_pub1, r_pub2, r_item_valid;
  logic [P_W-1:0]       r_cnt_x, r_cnt_y, r_x1, r_y1;
  logic [N_RECT*16-1:0] r_tgt;
  logic [C_W+1:0]       r_err;

  logic                 w_rise, w_fall, w_pix, w_acc_vld;
  logic [N_RECT*16-1:0] w_tgt;
  logic [C_W+1:0]       w_err;

  // r_vs1 resets high and r_active gates the fall, so a frame cut by reset never publishes.
  assign w_rise    = i_vs & ~r_vs1;
  assign w_fall    = ~i_vs & r_vs1 & r_active;
  assign w_pix     = i_valid & i_vs;
  assign w_acc_vld = w_pix & (r_active | w_rise);
  assign w_tgt     = w_rise ? i_target : r_tgt;
  assign w_err     = w_rise ? i_err : r_err;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_vs1        <= 1'b1;
      r_active     <= 1'b0;
      r_pub1       <= 1'b0;
      r_pub2       <= 1'b0;
      r_item_valid <= 1'b0;
      r_cnt_x      <= '0;
      r_cnt_y      <= '0;
      r_x1         <= '0;
      r_y1         <= '0;
      r_tgt        <= '0;
      r_err        <= '0;
    end else begin
      r_vs1        <= i_vs;
      r_pub1       <= w_fall;
      r_pub2       <= r_pub1;
      r_item_valid <= r_pub2;
      r_x1         <= r_cnt_x;
      r_y1         <= r_cnt_y;
      if (w_rise) begin
        r_active <= 1'b1;
        r_tgt    <= i_target;
        r_err    <= i_err;
      end else if (w_fall) begin
        r_active <= 1'b0;
      end
      if (!i_vs) begin
        r_cnt_x <= '0;
        r_cnt_y <= '0;
      end else if (i_valid) begin
        if (r_cnt_x == P_W'(IMG_X - 1)) begin
          r_cnt_x <= '0;
          r_cnt_y <= (r_cnt_y == P_W'(IMG_Y - 1)) ? '0 : r_cnt_y + 1'b1;
        end else begin
          r_cnt_x <= r_cnt_x + 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < N_RECT; k++) begin : g_slot
    rect_acc #(
      .C_W       (C_W),
      .P_W       (P_W),
      .CRD_SHIFT (CRD_SHIFT),
      .MIN_PIX   (MIN_PIX)
    ) u_acc (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .i_clr     (w_rise),
      .i_valid   (w_acc_vld),
      .i_data    (i_data),
      .i_target  (w_tgt[16*k +: 16]),
      .i_err     (w_err),
      .i_x       (r_x1),
      .i_y       (r_y1),
      .i_pub     (r_pub2),
      .o_item    (o_item[32*k +: 32])
    );
  end

  assign o_item_valid = r_item_valid;

endmodule

// File: tb/tb_rect_extract.sv
// Scoreboard bench for rect_extract on a 16x8 raster with two slots.
module tb_rect_extract;
  import rect_extract_pkg::*;

  localparam int NX = 16, NY = 8, NR = 2, NPIX = NX * NY, MINP = 4;
  localparam logic [31:0] EMPTY = 32'hFFFF_0000;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              i_vs = 1'b0, i_valid = 1'b0;
  logic [15:0]       i_data = '0;
  logic [5:0]        i_err = '0;
  logic [NR*16-1:0]  i_target = '0;
  logic [NR*32-1:0]  o_item;
  logic              o_item_valid;

  rect_extract #(
    .N_RECT(NR), .CRD_SHIFT(0), .MIN_PIX(MINP), .IMG_X(NX), .IMG_Y(NY)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .i_vs         (i_vs),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_err        (i_err),
    .i_target     (i_target),
    .o_item       (o_item),
    .o_item_valid (o_item_valid)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [NR*32-1:0] items;
    int               cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] fb [NPIX];
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic fill(input logic [15:0] v);
    for (int p = 0; p < NPIX; p++) fb[p] = v;
  endtask

  task automatic rect(input int x0, input int x1, input int y0, input int y1, input logic [15:0] v);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) fb[y*NX + x] = v;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [NR*32-1:0] model(input logic [NR*16-1:0] tg, input logic [5:0] err,
                                             input int npix);
    logic [NR*32-1:0] r;
    logic [15:0]      t, px;
    int               xmin, xmax, ymin, ymax, cnt, e;
    r = '0;
    e = int'(err);
    for (int k = 0; k < NR; k++) begin
      t = tg[16*k +: 16];
      xmin = 4095; ymin = 4095; xmax = 0; ymax = 0; cnt = 0;
      for (int p = 0; p < npix; p++) begin
        px = fb[p];
        if (iabs(int'(px[15:11]) - int'(t[15:11])) <= e &&
            iabs(int'(px[10:5])  - int'(t[10:5]))  <= e &&
            iabs(int'(px[4:0])   - int'(t[4:0]))   <= e) begin
          cnt++;
          if (p % NX < xmin) xmin = p % NX;
          if (p % NX > xmax) xmax = p % NX;
          if (p / NX < ymin) ymin = p / NX;
          if (p / NX > ymax) ymax = p / NX;
        end
      end
      r[32*k +: 32] = (cnt < MINP) ? EMPTY : {8'(xmin), 8'(ymin), 8'(xmax), 8'(ymax)};
    end
    return r;
  endfunction

  // rst_at >= 0 pulses reset for two pixels and expects no publish for that frame.
  task automatic drive_frame(input int npix, input int blank, input int chg_at,
                             input logic [NR*16-1:0] chg_tgt, input int rst_at);
    exp_t e;
    e.items = model(i_target, i_err, npix);
    for (int p = 0; p < npix; p++) begin
      @(posedge sys_clk); #1;
      if (p == chg_at) i_target = chg_tgt;
      if (p == rst_at) sys_rst_n = 1'b0;
      if (rst_at >= 0 && p == rst_at + 2) sys_rst_n = 1'b1;
      i_vs = 1'b1; i_valid = 1'b1; i_data = fb[p];
    end
    e.cyc = cyc + 4;
    if (rst_at < 0) sb.push_back(e);
    @(posedge sys_clk); #1;
    i_vs = 1'b0; i_valid = 1'b0; i_data = '0;
    repeat (blank - 1) @(posedge sys_clk);
  endtask

  exp_t mon_e;
  logic prev_vld = 1'b0;
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (prev_vld) chk("vld_pulse_width", 64'(o_item_valid), 64'd0);
      if (o_item_valid) begin
        if (sb.size() == 0) chk("unexpected_vld", 64'(o_item_valid), 64'd0);
        else begin
          mon_e = sb.pop_front();
          for (int k = 0; k < NR; k++)
            chk($sformatf("slot%0d", k), 64'(o_item[32*k +: 32]), 64'(mon_e.items[32*k +: 32]));
          chk("latency", 64'(cyc), 64'(mon_e.cyc));
        end
      end
    end
    prev_vld = o_item_valid;
  end

  initial begin
    repeat (3) @(posedge sys_clk); #1;
    chk("rst_item", 64'(o_item), 64'({NR{EMPTY}}));
    chk("rst_vld", 64'(o_item_valid), 64'd0);
    sys_rst_n = 1'b1;
    repeat (3) @(posedge sys_clk); #1;

    // red block, exact match
    fill(16'h0000); rect(3, 6, 2, 4, 16'hF800);
    i_target = {16'h001F, 16'hF800}; i_err = 6'd0;
    drive_frame(NPIX, 5, -1, '0, -1);
    repeat (6) @(posedge sys_clk); #1;
    chk("red_box_hold", 64'(o_item[31:0]), 64'h0302_0604);

    // reset during pixel 50 wipes held result and suppresses the publish
    drive_frame(NPIX, 5, -1, '0, 50);
    repeat (10) @(posedge sys_clk); #1;
    chk("rst_mid_item", 64'(o_item), 64'({NR{EMPTY}}));

    // tolerance: G off by one
    fill(16'h0000); rect(4, 7, 1, 1, 16'hF020);
    i_err = 6'd0; drive_frame(NPIX, 5, -1, '0, -1);
    i_err = 6'd1; drive_frame(NPIX, 5, -1, '0, -1);
    fb[1*NX + 7] = 16'h0000;
    drive_frame(40, 5, -1, '0, -1);

    // overlap: both slots on the same colour, corners of the frame
    fill(16'h0000);
    fb[0] = 16'h07E0; fb[NPIX-1] = 16'h07E0; fb[3*NX + 5] = 16'h07E0; fb[4*NX + 9] = 16'h07E0;
    i_target = {16'h07E0, 16'h07E0}; i_err = 6'd0;
    drive_frame(NPIX, 5, -1, '0, -1);

    // mid-frame target change, then 2-cycle blanking into the next frame
    fill(16'h0000); rect(2, 4, 1, 2, 16'hF800); rect(10, 12, 5, 6, 16'h001F);
    i_target = {16'h07E0, 16'hF800};
    drive_frame(NPIX, 2, 60, {16'h07E0, 16'h001F}, -1);
    fill(16'h0000); rect(8, 9, 0, 1, 16'h001F);
    drive_frame(NPIX, 5, -1, '0, -1);

    repeat (12) @(posedge sys_clk); #1;
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
